// File: rtl/npc_pkg.sv
// Shared opcodes and default address constants for the fetch-side next-PC unit.
package npc_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGEZ = 4'd4,
    BR_BGTZ = 4'd5,
    BR_BLTZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9,
    BR_JALR = 4'd10
  } br_op_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_TOP   = 32'h0000_6ffc;

endpackage

// File: rtl/npc_unit_if.sv
// Signal bundle between the pipeline (F/D stages) and the next-PC unit.
interface npc_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  import npc_pkg::*;

  logic            stall;
  logic            br_valid;
  br_op_e          br_op;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [15:0]     imm16;
  logic [25:0]     instr_index;
  logic            exc_req;
  logic            eret_req;
  logic [XLEN-1:0] epc;

  logic [XLEN-1:0]  pc_f;
  logic [XLEN-1:0]  pc4_f;
  logic             redirect;
  logic             adel_f;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] br_taken_cnt;

  modport master (
    output stall, br_valid, br_op, pc_d, rs_val, rt_val, imm16, instr_index,
    output exc_req, eret_req, epc,
    input  pc_f, pc4_f, redirect, adel_f, br_cnt, br_taken_cnt
  );

  modport slave (
    input  stall, br_valid, br_op, pc_d, rs_val, rt_val, imm16, instr_index,
    input  exc_req, eret_req, epc,
    output pc_f, pc4_f, redirect, adel_f, br_cnt, br_taken_cnt
  );

endinterface

// File: rtl/npc_cond.sv
// Branch/jump condition evaluation on raw forwarded operands (signed compare).
module npc_cond
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  br_op_e          br_op_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [XLEN-1:0] rt_val_i,
  output logic            taken_o
);

  logic signed [XLEN-1:0] rs_s;
  logic                   rs_zero;

  assign rs_s    = $signed(rs_val_i);
  assign rs_zero = (rs_val_i == '0);

  always_comb begin
    taken_o = 1'b0;
    unique case (br_op_i)
      BR_BEQ:  taken_o = (rs_val_i == rt_val_i);
      BR_BNE:  taken_o = (rs_val_i != rt_val_i);
      BR_BLEZ: taken_o = rs_s[XLEN-1] | rs_zero;
      BR_BGEZ: taken_o = ~rs_s[XLEN-1];
      BR_BGTZ: taken_o = ~rs_s[XLEN-1] & ~rs_zero;
      BR_BLTZ: taken_o = rs_s[XLEN-1];
      BR_J, BR_JAL, BR_JR, BR_JALR: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// Fetch PC register, next-PC selection, stall-safe redirect latch and branch statistics.
module npc_unit
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEF_EXC_VECTOR),
  parameter logic [XLEN-1:0] IMEM_TOP   = XLEN'(DEF_IMEM_TOP),
  parameter int unsigned     CNT_W      = 32
) (
  input logic       clk,
  input logic       reset,
  npc_unit_if.slave bus
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] br_taken_cnt_q, br_taken_cnt_d;

  logic            cond_taken;
  logic            take;
  logic            flush;
  logic            hold;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pc4_d_stage;
  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] target;

  npc_cond #(
    .XLEN (XLEN)
  ) u_cond (
    .br_op_i  (bus.br_op),
    .rs_val_i (bus.rs_val),
    .rt_val_i (bus.rt_val),
    .taken_o  (cond_taken)
  );

  assign pc4         = pc_q + XLEN'(4);
  assign pc4_d_stage = bus.pc_d + XLEN'(4);
  assign br_offset   = {{(XLEN-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign take        = bus.br_valid & ~pend_valid_q & cond_taken;
  assign flush       = bus.exc_req | bus.eret_req;
  assign hold        = bus.stall & ~flush;

  always_comb begin
    unique case (bus.br_op)
      BR_J, BR_JAL:    target = {pc4_d_stage[XLEN-1:28], bus.instr_index, 2'b00};
      BR_JR, BR_JALR:  target = bus.rs_val;
      default:         target = pc4_d_stage + br_offset;
    endcase
  end

  always_comb begin
    pc_d           = pc4;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    br_cnt_d       = br_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;

    if (bus.exc_req)        pc_d = EXC_VECTOR;
    else if (bus.eret_req)  pc_d = bus.epc;
    else if (bus.stall)     pc_d = pc_q;
    else if (pend_valid_q)  pc_d = pend_pc_q;
    else if (take)          pc_d = target;

    // A taken decision seen under stall is remembered so it survives D re-evaluation.
    if (flush) begin
      pend_valid_d = 1'b0;
    end else if (bus.stall) begin
      if (take) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = target;
      end
    end else begin
      pend_valid_d = 1'b0;
    end

    if (!bus.stall && !flush && bus.br_valid && (bus.br_op != BR_NONE)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
      if (cond_taken) br_taken_cnt_d = br_taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= RESET_PC;
      pend_valid_q   <= 1'b0;
      pend_pc_q      <= '0;
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      pc_q           <= pc_d;
      pend_valid_q   <= pend_valid_d;
      pend_pc_q      <= pend_pc_d;
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign bus.pc_f         = pc_q;
  assign bus.pc4_f        = pc4;
  assign bus.redirect     = ~hold & (pc_d != pc4);
  assign bus.adel_f       = (pc_q[1:0] != 2'b00) | (pc_q < RESET_PC) | (pc_q > IMEM_TOP);
  assign bus.br_cnt       = br_cnt_q;
  assign bus.br_taken_cnt = br_taken_cnt_q;

endmodule
